behavioural_halfadder: RTL and testbench
========================================

Name: behavioural_halfadder

Overview:
Bitwise half adder with two output paths:
- a zero-latency combinational sum/carry path.
- a one-cycle registered path with valid flag, plus a saturating count of carry-producing transactions.
It is a leaf arithmetic primitive used as a building block for ripple adders and counters, and for bring-up of the lab datapath.

Parameters:
WIDTH, 1, number of independent half-adder lanes (bit i of a/b feeds lane i); legal range 1..64
CNT_W, 8, width of the carry event counter; legal range 1..32

Ports:
clk  input  1  rising-edge clock for the registered path
rst  input  1  asynchronous, active-high reset for all registered state
a  input  WIDTH  addend A, one bit per lane
b  input  WIDTH  addend B, one bit per lane
in_valid  input  1  qualifies a/b for the registered path
s  output  WIDTH  combinational sum, s = a XOR b
c  output  WIDTH  combinational carry, c = a AND b
s_q  output  WIDTH  registered sum
c_q  output  WIDTH  registered carry
out_valid  output  1  s_q/c_q updated on the previous edge
carry_count  output  CNT_W  saturating count of accepted transactions with any lane carry set

Behaviour:
- Combinational path:
  - s[i] = a[i] ^ b[i], c[i] = a[i] & b[i] for every lane.
  - Zero latency; no dependency on clk, rst or in_valid.
  - Valid during reset.
  - Per-lane truth table: 00->s0 c0; 01->s1 c0; 10->s1 c0; 11->s0 c1.
- Reset (rst=1, asynchronous assert, takes effect immediately without a clock edge):
  - s_q=0, c_q=0, out_valid=0, carry_count=0.
  - While rst is high, all registers hold these values regardless of clock or inputs.
  - Registered logic resumes on the first rising clk edge with rst low.
- Registered path, each rising clk edge with rst=0:
  - in_valid=1: s_q<=a^b, c_q<=a&b, out_valid<=1.
  - in_valid=0: s_q and c_q hold their previous values; out_valid<=0.
  - Latency is exactly 1 cycle from the sampling edge to the result on s_q/c_q.
  - Back-to-back valid inputs give one result per cycle. There is no backpressure.
- carry_count:
  - On an edge with in_valid=1 and (a&b)!=0, increment by 1 (a per-transaction count, not per-lane).
  - Saturates at 2^CNT_W-1 and holds there. It never wraps.
  - Cleared only by rst.
- X/illegal handling: none required. Inputs are assumed driven.
- Reset mid-operation: a pending result is discarded and out_valid drops at reset assertion, not at the next edge.

Test Plan:
1. Truth table, WIDTH=1, no clock required: a,b = 00,01,10,11 applied at 10 ns intervals -> (s,c) = (0,0),(1,0),(1,0),(0,1), each settled within the same timestep.
2. Registered latency: rst pulse, then in_valid=1 with a=1,b=1 sampled at edge N -> at edge N: s_q=0, c_q=1, out_valid=1, carry_count=1. Next edge with in_valid=0 -> out_valid=0, s_q/c_q unchanged.
3. Vector lanes, WIDTH=8: a=8'hF0, b=8'hCC, in_valid=1 -> s=8'h3C, c=8'hC0 immediately; s_q=8'h3C, c_q=8'hC0 after one edge; carry_count +1.
4. Counter saturation, CNT_W=2: five consecutive valid transactions with a=b=1 -> carry_count reads 1,2,3,3,3. A transaction with a=1,b=0 leaves the count unchanged.
5. Async reset mid-stream: assert rst between clock edges while out_valid=1 and carry_count=3 -> s_q, c_q, out_valid and carry_count read 0 before the next edge. The combinational s/c still track a/b throughout.
6. Reset release: deassert rst, hold in_valid=0 for 3 edges -> all registered outputs remain 0. First valid a=0,b=1 -> s_q=1, c_q=0, carry_count=0.

Source files
------------

// File: rtl/behavioural_halfadder.sv
// Bitwise half adder lanes with a zero-latency combinational path and a
// one-cycle registered path that carries a valid flag and a saturating carry-event count.
module behavioural_halfadder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s_q,
  output logic [WIDTH-1:0] c_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_count
);

  logic any_carry;
  logic cnt_sat;

  assign s = a ^ b;
  assign c = a & b;

  // One increment per accepted transaction, no matter how many lanes carry.
  assign any_carry = |c;
  assign cnt_sat   = &carry_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '0;
      c_q         <= '0;
      out_valid   <= 1'b0;
      carry_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q <= s;
        c_q <= c;
      end
      if (in_valid && any_carry && !cnt_sat) begin
        carry_count <= carry_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_behavioural_halfadder.sv
// Directed bench: a 1-lane instance with a 2-bit counter and an 8-lane
// instance with an 8-bit counter, sharing clock and reset.
module tb_behavioural_halfadder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
  logic       s1, c1, s_q1, c_q1, ov1;
  logic [1:0] cnt1;

  logic [7:0] a8 = '0, b8 = '0;
  logic       v8 = 1'b0;
  logic [7:0] s8, c8, s_q8, c_q8, cnt8;
  logic       ov8;

  int n_checks = 0;
  int n_errors = 0;

  behavioural_halfadder #(.WIDTH(1), .CNT_W(2)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .s(s1), .c(c1), .s_q(s_q1), .c_q(c_q1), .out_valid(ov1), .carry_count(cnt1)
  );

  behavioural_halfadder #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
    .s(s8), .c(c8), .s_q(s_q8), .c_q(c_q8), .out_valid(ov8), .carry_count(cnt8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] tt_exp [4] = '{2'b00, 2'b10, 2'b10, 2'b01};  // {s,c}
  logic [1:0] sat_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_s_q1", s_q1, 0);
    check("rst_c_q1", c_q1, 0);
    check("rst_ov1", ov1, 0);
    check("rst_cnt1", cnt1, 0);
    check("rst_ov8", ov8, 0);
    check("rst_cnt8", cnt8, 0);

    // truth table on the combinational path, applied while still in reset
    for (int i = 0; i < 4; i++) begin
      a1 = tt_in[i][1];
      b1 = tt_in[i][0];
      #1;
      check($sformatf("tt_s_%0d", i), s1, tt_exp[i][1]);
      check($sformatf("tt_c_%0d", i), c1, tt_exp[i][0]);
      #9;
    end

    // registered latency, 1 lane
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    edge_sample();
    check("lat_s_q", s_q1, 0);
    check("lat_c_q", c_q1, 1);
    check("lat_ov", ov1, 1);
    check("lat_cnt", cnt1, 1);
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    edge_sample();
    check("idle_ov", ov1, 0);
    check("idle_s_q_hold", s_q1, 0);
    check("idle_c_q_hold", c_q1, 1);
    check("idle_cnt", cnt1, 1);

    // vector lanes
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'hCC; v8 = 1'b1;
    #1;
    check("vec_s", s8, 8'h3C);
    check("vec_c", c8, 8'hC0);
    edge_sample();
    check("vec_s_q", s_q8, 8'h3C);
    check("vec_c_q", c_q8, 8'hC0);
    check("vec_ov", ov8, 1);
    check("vec_cnt", cnt8, 1);
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'hF0;
    edge_sample();
    check("vec_nc_s_q", s_q8, 8'hFF);
    check("vec_nc_c_q", c_q8, 8'h00);
    check("vec_nc_cnt", cnt8, 1);
    @(negedge clk);
    v8 = 1'b0;

    // counter saturation with CNT_W=2, starting from a fresh reset
    rst = 1'b1;
    #2 rst = 1'b0;
    check("sat_pre_cnt", cnt1, 0);
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge_sample();
      check($sformatf("sat_cnt_%0d", i), cnt1, sat_exp[i]);
    end
    @(negedge clk);
    b1 = 1'b0;
    edge_sample();
    check("sat_nocarry_cnt", cnt1, 3);
    check("sat_nocarry_s_q", s_q1, 1);
    check("sat_nocarry_ov", ov1, 1);

    // async reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_s_q", s_q1, 0);
    check("arst_c_q", c_q1, 0);
    check("arst_ov", ov1, 0);
    check("arst_cnt", cnt1, 0);
    check("arst_comb_s", s1, 1);
    b1 = 1'b1;
    #1;
    check("arst_comb_s2", s1, 0);
    check("arst_comb_c2", c1, 1);

    // reset release with idle input, then first transaction
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      check($sformatf("rel_ov_%0d", i), ov1, 0);
      check($sformatf("rel_c_q_%0d", i), c_q1, 0);
      check($sformatf("rel_cnt_%0d", i), cnt1, 0);
    end
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
    edge_sample();
    check("rel_first_s_q", s_q1, 1);
    check("rel_first_c_q", c_q1, 0);
    check("rel_first_ov", ov1, 1);
    check("rel_first_cnt", cnt1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
